// File: rtl/vec_row_accum.sv
// Element-wise row accumulator: sums DATA_WIDTH-bit vectors until a last_in beat, then presents the row.
// Latency: row result valid the cycle after the last_in beat is accepted; one beat per cycle, no bubble between rows.
// Backpressure: while a result is held, rdy_out follows rdy_in so a new row only starts on the emitting cycle.

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 16
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

module vec_row_accum #(
    parameter int VEC_LEN    = `MAX_EMBEDDING_DIM,
    parameter int DATA_WIDTH = `INTEGER_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_in,
    output logic                  rdy_out,
    input  logic [DATA_WIDTH-1:0] data_in [VEC_LEN],
    input  logic                  last_in,
    output logic                  vld_out,
    input  logic                  rdy_in,
    output logic [DATA_WIDTH-1:0] sum_out [VEC_LEN],
    output logic [CNT_WIDTH-1:0]  count_out,
    output logic                  ovf_out
);

    // ACCUM covers both "idle" and "row in progress"; HOLD presents a finished row.
    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_acc [VEC_LEN];
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_ovf;

    logic                  w_acc_hs;
    logic                  w_out_hs;
    logic                  w_first;
    logic [DATA_WIDTH-1:0] w_sum [VEC_LEN];
    logic [VEC_LEN-1:0]    w_ovf_vec;
    logic                  w_any_ovf;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;

    // Handshake outputs; rdy_out depends on rdy_in only while holding a result.
    always_comb begin
        vld_out = 1'b0;
        rdy_out = 1'b1;
        if (r_state == S_HOLD) begin
            vld_out = 1'b1;
            rdy_out = rdy_in;
        end
    end

    assign w_acc_hs = vld_in && rdy_out;
    assign w_out_hs = vld_out && rdy_in;

    // An accepted beat starts a fresh row when nothing is accumulated yet, or when
    // it arrives in HOLD (which implies the held result is leaving this same cycle).
    assign w_first = (r_state == S_HOLD) || (r_cnt == '0);

    // Wrap-around element sums and per-element signed overflow detection.
    always_comb begin
        for (int i = 0; i < VEC_LEN; i++) begin
            w_sum[i]     = r_acc[i] + data_in[i];
            w_ovf_vec[i] = (r_acc[i][DATA_WIDTH-1] == data_in[i][DATA_WIDTH-1]) &&
                           (w_sum[i][DATA_WIDTH-1] != r_acc[i][DATA_WIDTH-1]);
        end
    end

    assign w_any_ovf = |w_ovf_vec;

    // Term counter sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACCUM: begin
                if (w_acc_hs && last_in) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_out_hs) begin
                    if (w_acc_hs && last_in) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end
            end
            default: w_state_nxt = S_ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, term counter and sticky overflow; held untouched during gaps and while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                r_acc[i] <= '0;
            end
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_acc_hs) begin
            if (w_first) begin
                for (int i = 0; i < VEC_LEN; i++) begin
                    r_acc[i] <= data_in[i];
                end
                r_cnt <= CNT_ONE;
                r_ovf <= 1'b0;
            end else begin
                for (int i = 0; i < VEC_LEN; i++) begin
                    r_acc[i] <= w_sum[i];
                end
                r_cnt <= w_cnt_inc;
                r_ovf <= r_ovf | w_any_ovf;
            end
        end else if (w_out_hs) begin
            // Row emitted with no new beat: clear so the next beat is treated as a first beat.
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

    assign sum_out   = r_acc;
    assign count_out = r_cnt;
    assign ovf_out   = r_ovf;

endmodule

// File: tb/tb_vec_row_accum.sv
// Directed bench for vec_row_accum with VEC_LEN=4, DATA_WIDTH=8, CNT_WIDTH=8.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Table vectors cover basic, overflow and back-to-back rows; hand sequences cover stalls, gaps and reset.

module tb_vec_row_accum;

    localparam int VL = 4;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          vld_in;
    logic          rdy_out;
    logic [DW-1:0] data_in [VL];
    logic          last_in;
    logic          vld_out;
    logic          rdy_in;
    logic [DW-1:0] sum_out [VL];
    logic [CW-1:0] count_out;
    logic          ovf_out;

    logic [31:0]   sum_pk;

    int tests;
    int fails;

    vec_row_accum #(
        .VEC_LEN    (VL),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vld_in    (vld_in),
        .rdy_out   (rdy_out),
        .data_in   (data_in),
        .last_in   (last_in),
        .vld_out   (vld_out),
        .rdy_in    (rdy_in),
        .sum_out   (sum_out),
        .count_out (count_out),
        .ovf_out   (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < VL; i++) begin
            sum_pk[8*i +: 8] = sum_out[i];
        end
    end

    typedef struct {
        logic        vld;
        logic        last;
        logic        rdy;
        logic [31:0] d;
        logic        e_vld;
        logic        e_rdy;
        logic        chk;
        logic [31:0] e_sum;
        logic [7:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    // Element 0 is the first argument.
    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] e);
        mk = {e, c, b, a};
    endfunction

    function automatic vec_t mkv(input logic v, input logic l, input logic r, input logic [31:0] d,
                                 input logic ev, input logic er, input logic ck,
                                 input logic [31:0] es, input logic [7:0] ec, input logic eo);
        vec_t t;
        t.vld = v; t.last = l; t.rdy = r; t.d = d;
        t.e_vld = ev; t.e_rdy = er; t.chk = ck;
        t.e_sum = es; t.e_cnt = ec; t.e_ovf = eo;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies inputs for one cycle (just after the falling edge) and waits for them to settle.
    task automatic drive(input logic v, input logic l, input logic r, input logic [31:0] d);
        @(negedge clk);
        vld_in  = v;
        last_in = l;
        rdy_in  = r;
        for (int i = 0; i < VL; i++) begin
            data_in[i] = d[8*i +: 8];
        end
        #1;
    endtask

    task automatic chk_all(input string name, input logic ev, input logic er,
                           input logic [31:0] es, input logic [7:0] ec, input logic eo);
        chk({name, ".vld_out"}, 32'(vld_out), 32'(ev));
        chk({name, ".rdy_out"}, 32'(rdy_out), 32'(er));
        chk({name, ".sum_out"}, sum_pk, es);
        chk({name, ".count_out"}, 32'(count_out), 32'(ec));
        chk({name, ".ovf_out"}, 32'(ovf_out), 32'(eo));
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        vld_in  = 1'b0;
        last_in = 1'b0;
        rdy_in  = 1'b1;
        for (int i = 0; i < VL; i++) data_in[i] = '0;

        // Basic row, overflow row plus follow-up, then four back-to-back single-beat rows.
        tbl[0]  = mkv(1'b1, 1'b0, 1'b1, mk(8'd1, 8'd2, 8'd3, 8'd4),       1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0);
        tbl[1]  = mkv(1'b1, 1'b0, 1'b1, mk(8'd10, 8'd10, 8'd10, 8'd10),   1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0);
        tbl[2]  = mkv(1'b1, 1'b1, 1'b1, mk(8'hff, 8'hff, 8'hff, 8'hff),   1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0);
        tbl[3]  = mkv(1'b0, 1'b0, 1'b1, 32'h0,                            1'b1, 1'b1, 1'b1, mk(8'd10, 8'd11, 8'd12, 8'd13), 8'd3, 1'b0);
        tbl[4]  = mkv(1'b1, 1'b0, 1'b1, mk(8'd100, 8'd0, 8'd0, 8'd0),     1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0);
        tbl[5]  = mkv(1'b1, 1'b1, 1'b1, mk(8'd100, 8'd0, 8'd0, 8'd0),     1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0);
        tbl[6]  = mkv(1'b1, 1'b1, 1'b1, mk(8'd1, 8'd1, 8'd1, 8'd1),       1'b1, 1'b1, 1'b1, mk(8'hc8, 8'd0, 8'd0, 8'd0), 8'd2, 1'b1);
        tbl[7]  = mkv(1'b0, 1'b0, 1'b1, 32'h0,                            1'b1, 1'b1, 1'b1, mk(8'd1, 8'd1, 8'd1, 8'd1), 8'd1, 1'b0);
        tbl[8]  = mkv(1'b1, 1'b1, 1'b1, mk(8'd1, 8'd1, 8'd1, 8'd1),       1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0);
        tbl[9]  = mkv(1'b1, 1'b1, 1'b1, mk(8'd2, 8'd2, 8'd2, 8'd2),       1'b1, 1'b1, 1'b1, mk(8'd1, 8'd1, 8'd1, 8'd1), 8'd1, 1'b0);
        tbl[10] = mkv(1'b1, 1'b1, 1'b1, mk(8'd3, 8'd3, 8'd3, 8'd3),       1'b1, 1'b1, 1'b1, mk(8'd2, 8'd2, 8'd2, 8'd2), 8'd1, 1'b0);
        tbl[11] = mkv(1'b1, 1'b1, 1'b1, mk(8'd4, 8'd4, 8'd4, 8'd4),       1'b1, 1'b1, 1'b1, mk(8'd3, 8'd3, 8'd3, 8'd3), 8'd1, 1'b0);
        tbl[12] = mkv(1'b0, 1'b0, 1'b1, 32'h0,                            1'b1, 1'b1, 1'b1, mk(8'd4, 8'd4, 8'd4, 8'd4), 8'd1, 1'b0);
        tbl[13] = mkv(1'b0, 1'b0, 1'b1, 32'h0,                            1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("reset", 1'b0, 1'b1, 32'h0, 8'd0, 1'b0);

        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].vld, tbl[k].last, tbl[k].rdy, tbl[k].d);
            chk($sformatf("vec%0d.vld_out", k), 32'(vld_out), 32'(tbl[k].e_vld));
            chk($sformatf("vec%0d.rdy_out", k), 32'(rdy_out), 32'(tbl[k].e_rdy));
            if (tbl[k].chk) begin
                chk($sformatf("vec%0d.sum_out", k), sum_pk, tbl[k].e_sum);
                chk($sformatf("vec%0d.count_out", k), 32'(count_out), 32'(tbl[k].e_cnt));
                chk($sformatf("vec%0d.ovf_out", k), 32'(ovf_out), 32'(tbl[k].e_ovf));
            end
        end

        // Backpressure: row {1}+{2} completes while rdy_in is low; a pending beat waits 5 cycles.
        drive(1'b1, 1'b0, 1'b0, mk(8'd1, 8'd1, 8'd1, 8'd1));
        drive(1'b1, 1'b1, 1'b0, mk(8'd2, 8'd2, 8'd2, 8'd2));
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 1'b0, mk(8'd7, 8'd7, 8'd7, 8'd7));
            chk_all($sformatf("stall%0d", c), 1'b1, 1'b0, mk(8'd3, 8'd3, 8'd3, 8'd3), 8'd2, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b1, mk(8'd7, 8'd7, 8'd7, 8'd7));
        chk_all("release", 1'b1, 1'b1, mk(8'd3, 8'd3, 8'd3, 8'd3), 8'd2, 1'b0);
        drive(1'b1, 1'b1, 1'b1, mk(8'd1, 8'd1, 8'd1, 8'd1));
        chk("bp_next.vld_out", 32'(vld_out), 32'd0);
        chk("bp_next.count_out", 32'(count_out), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        chk_all("bp_row2", 1'b1, 1'b1, mk(8'd8, 8'd8, 8'd8, 8'd8), 8'd2, 1'b0);

        // Gaps and saturation: 300 beats of {0,0,0,1}; 127+1 wraps, so overflow is flagged.
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 1'b0, 1'b1, mk(8'd0, 8'd0, 8'd0, 8'd1));
        end
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        chk("gap1.sum_out", sum_pk, mk(8'd0, 8'd0, 8'd0, 8'd10));
        chk("gap1.count_out", 32'(count_out), 32'd10);
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        chk("gap2.sum_out", sum_pk, mk(8'd0, 8'd0, 8'd0, 8'd10));
        chk("gap2.count_out", 32'(count_out), 32'd10);
        begin
            int n;
            n = 10;
            while (n < 300) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive(1'b0, 1'b0, 1'b1, 32'h0);
                end else begin
                    drive(1'b1, (n == 299), 1'b1, mk(8'd0, 8'd0, 8'd0, 8'd1));
                    n++;
                end
            end
        end
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        chk_all("sat", 1'b1, 1'b1, mk(8'd0, 8'd0, 8'd0, 8'd44), 8'd255, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        chk("sat_drop.vld_out", 32'(vld_out), 32'd0);

        // Reset after 2 of 3 beats, then a single-beat row.
        drive(1'b1, 1'b0, 1'b1, mk(8'd9, 8'd9, 8'd9, 8'd9));
        drive(1'b1, 1'b0, 1'b1, mk(8'd9, 8'd9, 8'd9, 8'd9));
        @(negedge clk);
        rst    = 1'b1;
        vld_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        vld_in  = 1'b1;
        last_in = 1'b1;
        for (int i = 0; i < VL; i++) data_in[i] = 8'd5;
        #1;
        chk_all("post_rst", 1'b0, 1'b1, 32'h0, 8'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        chk_all("rst_row", 1'b1, 1'b1, mk(8'd5, 8'd5, 8'd5, 8'd5), 8'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vec_row_accum.md
# vec_row_accum

Row accumulator that sits directly downstream of the element-wise vector adder in the output path of the attention datapath. It consumes a stream of DATA_WIDTH-bit vectors, one per key step, and sums them element-wise into an internal accumulator until a beat flagged `last_in` arrives. It then presents the finished row vector, the number of terms summed and a sticky signed-overflow flag to the next stage under a valid/ready handshake. It supports back-to-back rows with no bubble.

## Interface
- `VEC_LEN`, default `` `MAX_EMBEDDING_DIM ``: elements per vector.
- `DATA_WIDTH`, default `` `INTEGER_WIDTH ``: bits per element, two's complement signed.
- `CNT_WIDTH`, default 8: width of the term counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `vld_in` input 1: upstream beat valid.
- `rdy_out` output 1: this block can accept a beat.
- `data_in` input `[DATA_WIDTH-1:0] [VEC_LEN]`: incoming vector, from the adder's `sum`.
- `last_in` input 1: final beat of the current row; qualified by `vld_in`.
- `vld_out` output 1: completed row is presented.
- `rdy_in` input 1: downstream ready.
- `sum_out` output `[DATA_WIDTH-1:0] [VEC_LEN]`: accumulated row vector.
- `count_out` output CNT_WIDTH: terms summed into `sum_out`. Saturates at all-ones.
- `ovf_out` output 1: at least one element overflowed (signed) during this row.

## Operation
- The block has two states: ACCUM (row in progress, or idle) and HOLD (result presented).
- Accept: `acc_hs = vld_in && rdy_out`. Emit: `out_hs = vld_out && rdy_in`.
- In ACCUM, `rdy_out` = 1 and `vld_out` = 0.
  - On `acc_hs` with count == 0 (first beat): acc <= data_in, count <= 1, ovf <= 0.
  - On `acc_hs` otherwise: acc[i] <= acc[i] + data_in[i], truncated to DATA_WIDTH (wrap-around). count <= count + 1, held at all-ones once reached. ovf <= ovf OR any signed overflow. A signed overflow means both operands have the same sign bit and the result sign differs.
  - If `last_in` is set on the accepted beat, go to HOLD.
- In HOLD, `vld_out` = 1 and `rdy_out` = `rdy_in`. `sum_out`, `count_out` and `ovf_out` are stable until `out_hs`.
  - On `out_hs` without `acc_hs`: go to ACCUM, count <= 0, ovf <= 0. The acc contents are don't-care.
  - On `out_hs` with `acc_hs` in the same cycle: start the new row with acc <= data_in, count <= 1, ovf <= 0. Next state is HOLD if `last_in`, else ACCUM.
  - Upstream is never accepted in HOLD while `rdy_in` = 0.
- `sum_out`, `count_out` and `ovf_out` drive directly from the acc, count and ovf registers. They are only meaningful while `vld_out` = 1.
- `data_in` and `last_in` are ignored when `acc_hs` = 0.

## Timing
- Reset values: state ACCUM, acc = 0, count = 0, ovf = 0. Outputs: `vld_out` = 0, `rdy_out` = 1, `sum_out` = 0, `count_out` = 0, `ovf_out` = 0.
- Latency: the `last_in` beat accepted at edge N gives `vld_out` = 1 in the cycle after edge N, with the final sum already included.
- Throughput: one beat per cycle. A single-beat row (`last_in` on the first beat) followed by back-to-back single-beat rows sustains one row per cycle while `rdy_in` = 1.
- `rdy_out` is combinational from `rdy_in` in HOLD only. There is no other combinational input-to-output path.
- `vld_out`, once asserted, does not drop until `out_hs`. Its data does not change while `vld_out` = 1 and `rdy_in` = 0.
- Reset mid-row or in HOLD discards everything. `vld_out` is 0 in the cycle after reset.
- Gaps (`vld_in` = 0) inside a row leave acc and count unchanged.

## Test plan
Run all scenarios with VEC_LEN=4, DATA_WIDTH=8, CNT_WIDTH=8.

- **Basic row:** three beats {1,2,3,4}, {10,10,10,10}, {-1,-1,-1,-1}+last, with `rdy_in` = 1.
  - Required: `vld_out` = 1 in the cycle after the third accept, `sum_out` = {10,11,12,13}, `count_out` = 3, `ovf_out` = 0, `vld_out` drops next cycle.
- **Overflow:** beats {100,0,0,0}, {100,0,0,0}+last.
  - Required: `sum_out[0]` = -56 (0xC8), `ovf_out` = 1.
  - A following row {1,1,1,1}+last must show `ovf_out` = 0, `sum_out` = {1,1,1,1}, `count_out` = 1.
- **Backpressure:** complete a row with `rdy_in` = 0 for 5 cycles while `vld_in` = 1.
  - Required: `rdy_out` = 0 throughout, outputs stable, no beat consumed.
  - Raising `rdy_in` gives `out_hs` and the pending beat accepted in the same cycle as the first beat of the next row.
- **Back-to-back singles:** four consecutive beats, all with `last_in`, values {k,k,k,k} for k=1..4, `rdy_in` = 1.
  - Required: `vld_out` high for four consecutive cycles, outputting {k,k,k,k}, each with `count_out` = 1.
- **Gaps and saturation:**
  - A row of 300 beats of {0,0,0,1} with random `vld_in` gaps gives `count_out` = 255 and `sum_out[3]` = 300 mod 256 = 44.
  - A gap cycle must not change acc.
- **Reset mid-operation:** assert `rst` after 2 of 3 beats, then send one beat {5,5,5,5}+last.
  - Required: all outputs at reset values for the cycle after reset, then `sum_out` = {5,5,5,5}, `count_out` = 1.
